// File: rtl/multi_clock_gate_pkg.sv
// Shared types, default parameters and configuration checks for the
// multi-channel clock-gating controller.
package multi_clock_gate_pkg;

  localparam int unsigned NUM_CH_DEF      = 4;
  localparam int unsigned IDLE_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } ch_state_e;

  // True when the idle hold-off count is representable in the counter.
  function automatic bit idle_fits(input int unsigned idle, input int unsigned cnt_w);
    if (cnt_w >= 32) return 1'b1;
    return idle < (32'd1 << cnt_w);
  endfunction

  function automatic bit num_ch_ok(input int unsigned n);
    return (n >= 1) && (n <= 32);
  endfunction

endpackage

// File: rtl/icg_cell.sv
// Integrated clock-gate cell: low-transparent latch followed by an AND.
// Swap this module for a library ICG when targeting a real cell library.
module icg_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);

  logic r_lat;

  // Enable only moves while clk is low, so gclk pulses are whole high phases.
  always_latch begin
    if (!clk) r_lat <= en | test_en;
  end

  assign gclk = clk & r_lat;

endmodule

// File: rtl/multi_clock_gate.sv
// Multi-channel clock-gating controller: per-channel OFF/WAKE/ON/HOLD FSM
// with an idle hold-off counter, driving one icg_cell per channel.
module multi_clock_gate
  import multi_clock_gate_pkg::*;
#(
  parameter int unsigned NUM_CH      = NUM_CH_DEF,
  parameter int unsigned IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en_req,
  input  logic [NUM_CH-1:0] busy,
  input  logic              test_en,
  output logic [NUM_CH-1:0] gated_clk,
  output logic [NUM_CH-1:0] clk_on
);

  if (!idle_fits(IDLE_CYCLES, CNT_W)) begin : g_bad_cnt_w
    $error("multi_clock_gate: IDLE_CYCLES does not fit in CNT_W bits");
  end

  if (!num_ch_ok(NUM_CH)) begin : g_bad_num_ch
    $error("multi_clock_gate: NUM_CH must be in 1..32");
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    ch_state_e        r_state;
    ch_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_gate_en;
    logic             r_clk_on;

    // Next-state and hold-off counter.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        ST_OFF: begin
          if (en_req[i]) w_state_nxt = ST_WAKE;
        end
        ST_WAKE: begin
          w_state_nxt = ST_ON;
        end
        ST_ON: begin
          if (!en_req[i] && !busy[i]) begin
            if (IDLE_CYCLES == 0) begin
              w_state_nxt = ST_OFF;
            end else begin
              w_state_nxt = ST_HOLD;
              w_cnt_nxt   = CNT_W'(IDLE_CYCLES - 1);
            end
          end
        end
        ST_HOLD: begin
          if (en_req[i] || busy[i]) begin
            w_state_nxt = ST_ON;
          end else if (r_cnt == '0) begin
            w_state_nxt = ST_OFF;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
    end

    // Gate enable and status are registered from the next state so the
    // latch opens in the low phase right after the request edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state   <= ST_OFF;
        r_cnt     <= '0;
        r_gate_en <= 1'b0;
        r_clk_on  <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_gate_en <= (w_state_nxt != ST_OFF);
        r_clk_on  <= (w_state_nxt == ST_ON) || (w_state_nxt == ST_HOLD);
      end
    end

    assign clk_on[i] = r_clk_on;

    icg_cell u_icg (
      .clk     (clk),
      .en      (r_gate_en),
      .test_en (test_en),
      .gclk    (gated_clk[i])
    );
  end

endmodule

// File: doc/multi_clock_gate.md
# multi_clock_gate

Parametrised multi-channel clock-gating controller, the successor to the single-channel latch-based gate. Each channel turns a request/activity pair into a glitch-free gated clock, with a fixed one-cycle wake-up, an idle hold-off timer before shutdown, and a per-channel "clock running" status. It sits between the power-management logic and the clock inputs of gated subsystems. A global test enable forces every gate open.

## Interface
- NUM_CH, default 4: number of independent gated-clock channels, 1..32.
- IDLE_CYCLES, default 4: idle cycles held open after activity ends, 0..255.
- CNT_W, default 8: idle counter width; must satisfy 2^CNT_W > IDLE_CYCLES.

- clk  in  1: source clock; all state updates on the rising edge.
- rst  in  1: synchronous, active-high reset.
- en_req  in  NUM_CH: per-channel clock request from power management; level.
- busy  in  NUM_CH: per-channel activity indication from the gated subsystem; keeps the gate open.
- test_en  in  1: scan/test override; forces all gates open.
- gated_clk  out  NUM_CH: per-channel gated clock.
- clk_on  out  NUM_CH: registered status; high while the channel is in ON or HOLD.

## Operation
- Per-channel FSM with states OFF, WAKE, ON, HOLD, and a CNT_W-bit down-counter.
- OFF: when en_req is high, go to WAKE.
- WAKE: go to ON unconditionally. Lasts exactly one cycle; en_req dropping here is ignored.
- ON, when en_req and busy are both low:
  - IDLE_CYCLES > 0: go to HOLD and load cnt = IDLE_CYCLES-1.
  - IDLE_CYCLES = 0: go straight to OFF.
- HOLD, evaluated in priority order:
  - en_req or busy high: go to ON.
  - cnt == 0: go to OFF.
  - Otherwise decrement cnt.
- busy alone never wakes a channel from OFF; only en_req does.
- gate_en[i] is registered, high in WAKE, ON and HOLD.
- gated_clk[i] = clk AND lat[i]. lat[i] is a latch that is transparent while clk is low and captures (gate_en[i] OR test_en).
- test_en is combinational into the latch D input. It affects neither the FSM nor clk_on.
- Channels are fully independent and share no state.
- Reset:
  - All FSMs go to OFF, cnt to 0, gate_en to 0, clk_on to 0.
  - gated_clk stays low from the first clk-low phase after reset is sampled, unless test_en is high.
  - Reset in the middle of WAKE or HOLD aborts immediately, with no extra gated pulses after the next low phase.

## Timing
- Wake-up: en_req is sampled high at edge k.
  - State becomes WAKE at k; the latch opens in the low phase after k.
  - The first gated_clk rising edge is at edge k+1.
  - clk_on rises at edge k+1, so it is visible from the first gated pulse.
- Shutdown: en_req and busy are both sampled low at edge n while in ON.
  - gated_clk pulses continue through edge n+IDLE_CYCLES inclusive, then stop.
  - clk_on falls at edge n+IDLE_CYCLES.
  - With IDLE_CYCLES = 0, the last pulse is at edge n.
- Gated pulses are always full clk high phases. No runt or glitch when gate_en or test_en toggles, provided test_en is stable in the clk-high phase.
- en_req re-asserted in HOLD at any cnt, including cnt = 0: back to ON with no gap in gated_clk.
- Minimum off time is one cycle: OFF is sampled, then WAKE on the next request.

## Structure
- Package multi_clock_gate_pkg holds:
  - the state enum (OFF, WAKE, ON, HOLD), 2 bits;
  - the localparam defaults;
  - an elaboration check that IDLE_CYCLES fits in CNT_W.
- Sub-module icg_cell: latch plus AND, with ports clk, en, test_en, gclk. It is instanced once per channel inside a generate loop, and is the single point to swap for a library ICG.
- The per-channel FSM and counter stay inline in the generate loop.

## Test plan
- Reset, then idle: rst held for 2 cycles with en_req=0 and test_en=0. Required: gated_clk=0 and clk_on=0 on all channels for 10 cycles.
- Wake and shutdown: NUM_CH=4, IDLE_CYCLES=4, en_req[0] high at edge 3, low at edge 10, busy=0.
  - First gated_clk[0] pulse and clk_on[0] rise at edge 4.
  - Last pulse at edge 14; clk_on[0] falls at edge 14.
  - Channels 1–3 stay silent throughout.
- Busy extension: en_req[1] pulses for 1 cycle, busy[1] is high for 6 cycles afterwards.
  - Gate stays open through busy, plus 4 cycles.
  - Count gated pulses = 1 (WAKE) + 6 + 4 + boundary pulses per the timing rules.
- HOLD re-entry: en_req[2] re-asserted when cnt=0. Required: continuous gated_clk[2], no missing pulse, state back to ON.
- IDLE_CYCLES=0 build: en_req dropped at edge n. Required: last pulse at edge n, clk_on low after edge n.
- Test override and glitch checks:
  - test_en high while all channels are OFF and during rst: all gated_clk follow clk from the next low phase, and clk_on stays 0.
  - Toggling test_en and en_req at random low-phase points produces no gated_clk pulse narrower than clk high (assertion).
